// File: rtl/sar_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sar_pkg : shared state encoding and comparator one-hot check for sar_search
// Revision 1.0
// ----------------------------------------------------------------------------
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SET   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } sar_state_t;

  // Legal comparator codes, packed as {gt, eq, lt}
  localparam logic [2:0] C_CMP_GT = 3'b100;
  localparam logic [2:0] C_CMP_EQ = 3'b010;
  localparam logic [2:0] C_CMP_LT = 3'b001;

  function automatic logic cmp_onehot(input logic [2:0] cmp);
    return (cmp == C_CMP_GT) || (cmp == C_CMP_EQ) || (cmp == C_CMP_LT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_search.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sar_search : successive-approximation search driving an external comparator
// Revision 1.0
// ----------------------------------------------------------------------------
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] C_IDX_TOP = IW'(WIDTH - 1);

  sar_state_t       state_q,  state_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [IW-1:0]    idx_q,    idx_d;
  logic [WIDTH-1:0] guess_q,  guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q,    err_d;
  logic [2:0]       w_cmp;

  assign w_cmp = {cmp_gt, cmp_eq, cmp_lt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      idx_q    <= C_IDX_TOP;
      guess_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    guess_d  = guess_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d    = '0;
          err_d    = 1'b0;
          result_d = '0;
          idx_d    = C_IDX_TOP;
          state_d  = ST_SET;
        end
      end

      ST_SET: begin
        guess_d = acc_q | (WIDTH'(1) << idx_q);
        state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (!cmp_onehot(w_cmp)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (cmp_eq) begin
          acc_d   = guess_q;
          state_d = ST_DONE;
        end else begin
          if (cmp_gt) begin
            acc_d[idx_q] = 1'b1;
          end
          if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = ST_SET;
          end
        end
        // Publish the answer on entry to DONE so it is valid while done is high
        if (state_d == ST_DONE) begin
          result_d = acc_d;
        end
      end

      ST_DONE: begin
        result_d = acc_q;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign err    = err_q;
  assign busy   = (state_q == ST_SET) || (state_q == ST_CHECK);
  assign done   = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sar_search.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sar_search : table-driven self-checking bench for sar_search (WIDTH=4)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cmp_gt, cmp_eq, cmp_lt;
  logic [3:0] guess;
  logic       busy, done, err;
  logic [3:0] result;

  logic [3:0] tgt;
  logic       force_bad;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the cascade comparator (a=target, b=guess)
  assign cmp_gt = force_bad ? 1'b1 : (tgt > guess);
  assign cmp_eq = force_bad ? 1'b0 : (tgt == guess);
  assign cmp_lt = force_bad ? 1'b1 : (tgt < guess);

  sar_search #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .cmp_lt (cmp_lt),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  typedef struct {
    logic [3:0]  target;
    logic        bad;
    logic        spam;
    int          ng;
    logic [15:0] gs;
    int          done_cyc;
    logic [3:0]  res;
    logic        e;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int done_cyc;
    int gi;
    done_cyc = 0;
    gi = 0;
    @(posedge clk); #1;
    tgt = v.target;
    force_bad = v.bad;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 14 && done_cyc == 0; c++) begin
      @(negedge clk);
      start = v.spam && (c == 3 || c == 9);
      if (c == 1) begin
        chk($sformatf("v%0d start_clears_result", n), result, 0);
        chk($sformatf("v%0d start_clears_err", n), err, 0);
        chk($sformatf("v%0d busy_c1", n), busy, 1);
      end
      if (busy && (c % 2 == 0)) begin
        if (gi < 4) chk($sformatf("v%0d guess%0d", n, gi), guess, v.gs[15 - 4*gi -: 4]);
        gi++;
      end
      if (done) begin
        done_cyc = c;
        chk($sformatf("v%0d result_on_done", n), result, v.res);
        chk($sformatf("v%0d err_on_done", n), err, v.e);
        chk($sformatf("v%0d busy_on_done", n), busy, 0);
      end
    end
    chk($sformatf("v%0d done_cycle", n), done_cyc, v.done_cyc);
    chk($sformatf("v%0d guess_count", n), gi, v.ng);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d done_one_cycle", n), done, 0);
    chk($sformatf("v%0d idle_after_done", n), busy, 0);
    chk($sformatf("v%0d result_held", n), result, v.res);
    chk($sformatf("v%0d err_held", n), err, v.e);
    @(negedge clk);
    chk($sformatf("v%0d no_requeue", n), busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tgt = 4'd0;
    force_bad = 1'b0;

    vecs[0] = '{4'd9,  1'b0, 1'b0, 4, 16'h8CA9, 9, 4'd9,  1'b0};
    vecs[1] = '{4'd8,  1'b0, 1'b0, 1, 16'h8000, 3, 4'd8,  1'b0};
    vecs[2] = '{4'd0,  1'b0, 1'b0, 4, 16'h8421, 9, 4'd0,  1'b0};
    vecs[3] = '{4'd15, 1'b0, 1'b0, 4, 16'h8CEF, 9, 4'd15, 1'b0};
    vecs[4] = '{4'd6,  1'b0, 1'b0, 3, 16'h8460, 7, 4'd6,  1'b0};
    vecs[5] = '{4'd5,  1'b0, 1'b0, 4, 16'h8465, 9, 4'd5,  1'b0};
    vecs[6] = '{4'd3,  1'b1, 1'b0, 1, 16'h8000, 3, 4'd0,  1'b1};
    vecs[7] = '{4'd9,  1'b0, 1'b1, 4, 16'h8CA9, 9, 4'd9,  1'b0};

    #12;
    chk("reset_guess", guess, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a search: outputs clear, no done pulse, no restart
    begin
      int saw_done;
      saw_done = 0;
      @(posedge clk); #1;
      tgt = 4'd9;
      force_bad = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (done) saw_done = 1;
      end
      rst = 1'b1;
      #1;
      chk("midrst_guess", guess, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      chk("midrst_err", err, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done || busy) saw_done = 1;
      end
      chk("midrst_no_done_no_restart", saw_done, 0);
      chk("midrst_result_stays", result, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
